race_game_fsm: RTL and testbench

- Top-level game sequencer for the racing game; owns the game state and drives the text overlay enables (start_en, crash_en, finish_en), the pause line shared by the timer text and the motion logic, and the track/car motion enable.
- Consumes the per-frame refresh_tick plus debounced buttons and the collision/finish flags from the track logic.
- All outputs are registered (Moore machine).

---
 rtl/game_pkg.sv | 29 ++
 rtl/btn_edge.sv | 21 ++
 rtl/race_game_fsm.sv | 170 +++++++++++++++++
 tb/tb_race_game_fsm.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the racing game sequencer and its overlays.
// State encodings here are also what the debug state port reports.
package game_pkg;

  typedef enum logic [2:0] {
    ST_TITLE      = 3'd0,
    ST_RUN        = 3'd1,
    ST_PAUSED     = 3'd2,
    ST_CRASH_HOLD = 3'd3,
    ST_GAME_OVER  = 3'd4,
    ST_FINISH     = 3'd5
  } state_e;

  localparam int LIVES_DEFAULT = 3;
  localparam int BLINK_DEFAULT = 30;
  localparam int HOLD_DEFAULT  = 120;

  localparam logic [11:0] OVL_START_RGB  = 12'hFF0;
  localparam logic [11:0] OVL_CRASH_RGB  = 12'hF00;
  localparam logic [11:0] OVL_FINISH_RGB = 12'h0F0;
  localparam logic [11:0] OVL_TIMER_RGB  = 12'hFFF;

  function automatic logic [1:0] lives_dec(
    input logic [1:0] l
  );
    return (l == 2'd0) ? 2'd0 : l - 2'd1;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced button level.
// prev resets high so a button held through reset yields no press.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic press
);

  logic prev_q;
  logic prev_d;

  assign prev_d = level;
  assign press  = level & ~prev_q;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= 1'b1;
    else       prev_q <= prev_d;
  end

endmodule

// File: rtl/race_game_fsm.sv
// Game sequencer: owns game state, lives, overlay enables and motion gating.
// All outputs are registered from the next-state decode (Moore).
module race_game_fsm
  import game_pkg::*;
#(
  parameter int BLINK_FRAMES = BLINK_DEFAULT,
  parameter int HOLD_FRAMES  = HOLD_DEFAULT,
  parameter int LIVES        = LIVES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic       crash,
  input  logic       finish,
  output logic       start_en,
  output logic       crash_en,
  output logic       finish_en,
  output logic       pause,
  output logic       game_run,
  output logic       timer_reset,
  output logic [1:0] lives,
  output logic [2:0] state
);

  localparam int FW = $clog2(HOLD_FRAMES + 1);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [FW-1:0] HOLD_C  = FW'(HOLD_FRAMES);
  localparam logic [BW-1:0] BLINK_C = BW'(BLINK_FRAMES);
  localparam logic [1:0]    LIVES_C = 2'(LIVES);

  state_e          state_q, state_d;
  logic [FW-1:0]   frame_q, frame_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic            phase_q, phase_d;
  logic [1:0]      lives_q, lives_d;
  logic            start_en_q, start_en_d;
  logic            crash_en_q, crash_en_d;
  logic            finish_en_q, finish_en_d;
  logic            pause_q, pause_d;
  logic            run_q, run_d;
  logic            tr_q, tr_d;
  logic            start_p;
  logic            pause_p;
  logic            held;

  btn_edge u_start_edge (
    .clk   (clk),
    .reset (reset),
    .level (btn_start),
    .press (start_p)
  );

  btn_edge u_pause_edge (
    .clk   (clk),
    .reset (reset),
    .level (btn_pause),
    .press (pause_p)
  );

  assign held = (frame_q == HOLD_C);

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    tr_d    = 1'b0;
    case (state_q)
      ST_TITLE: begin
        if (start_p) begin
          state_d = ST_RUN;
          lives_d = LIVES_C;
          tr_d    = 1'b1;
        end
      end
      ST_RUN: begin
        if (finish) begin
          state_d = ST_FINISH;
        end else if (crash) begin
          if (lives_q <= 2'd1) begin
            state_d = ST_GAME_OVER;
            lives_d = 2'd0;
          end else begin
            state_d = ST_CRASH_HOLD;
            lives_d = lives_dec(lives_q);
          end
        end else if (pause_p) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (pause_p) state_d = ST_RUN;
      end
      ST_CRASH_HOLD: begin
        if (held && !crash) state_d = ST_RUN;
      end
      ST_GAME_OVER, ST_FINISH: begin
        if (held && start_p) state_d = ST_TITLE;
      end
      default: state_d = ST_TITLE;
    endcase

    if (state_d != state_q)
      frame_d = '0;
    else if (refresh_tick && !held)
      frame_d = frame_q + 1'b1;
    else
      frame_d = frame_q;

    // Blink phase flips on the tick after BLINK_FRAMES ticks were counted
    blink_d = blink_q;
    phase_d = phase_q;
    if (state_q != ST_TITLE || state_d != ST_TITLE) begin
      blink_d = '0;
      phase_d = 1'b1;
    end else if (refresh_tick) begin
      if (blink_q == BLINK_C) begin
        blink_d = {{(BW-1){1'b0}}, 1'b1};
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end

    start_en_d  = (state_d == ST_TITLE) && phase_d;
    crash_en_d  = (state_d == ST_CRASH_HOLD) ||
                  (state_d == ST_GAME_OVER);
    finish_en_d = (state_d == ST_FINISH);
    run_d       = (state_d == ST_RUN);
    pause_d     = (state_d != ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_TITLE;
      frame_q     <= '0;
      blink_q     <= '0;
      phase_q     <= 1'b1;
      lives_q     <= LIVES_C;
      start_en_q  <= 1'b1;
      crash_en_q  <= 1'b0;
      finish_en_q <= 1'b0;
      pause_q     <= 1'b1;
      run_q       <= 1'b0;
      tr_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      blink_q     <= blink_d;
      phase_q     <= phase_d;
      lives_q     <= lives_d;
      start_en_q  <= start_en_d;
      crash_en_q  <= crash_en_d;
      finish_en_q <= finish_en_d;
      pause_q     <= pause_d;
      run_q       <= run_d;
      tr_q        <= tr_d;
    end
  end

  assign start_en    = start_en_q;
  assign crash_en    = crash_en_q;
  assign finish_en   = finish_en_q;
  assign pause       = pause_q;
  assign game_run    = run_q;
  assign timer_reset = tr_q;
  assign lives       = lives_q;
  assign state       = state_q;

endmodule

// File: tb/tb_race_game_fsm.sv
// Scenario bench for race_game_fsm with a queue scoreboard of expected outputs.
// Small frame constants keep every scenario to a handful of cycles.
module tb_race_game_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic       refresh_tick;
  logic       btn_start;
  logic       btn_pause;
  logic       crash;
  logic       finish;
  logic       start_en;
  logic       crash_en;
  logic       finish_en;
  logic       pause;
  logic       game_run;
  logic       timer_reset;
  logic [1:0] lives;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  logic armed = 1'b0;
  logic [10:0] exp_q [$];
  logic [10:0] got;
  logic [10:0] want;

  race_game_fsm #(
    .BLINK_FRAMES (2),
    .HOLD_FRAMES  (4),
    .LIVES        (2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .refresh_tick (refresh_tick),
    .btn_start    (btn_start),
    .btn_pause    (btn_pause),
    .crash        (crash),
    .finish       (finish),
    .start_en     (start_en),
    .crash_en     (crash_en),
    .finish_en    (finish_en),
    .pause        (pause),
    .game_run     (game_run),
    .timer_reset  (timer_reset),
    .lives        (lives),
    .state        (state)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] S(
    input logic r, tk, bs, bp, cr, fi
  );
    return {r, tk, bs, bp, cr, fi};
  endfunction

  function automatic logic [10:0] mk(
    input logic [2:0] st, input logic [1:0] lv,
    input logic se, ce, fe, pa, gr, tr
  );
    return {st, lv, se, ce, fe, pa, gr, tr};
  endfunction

  function automatic logic [10:0] ex_title(input logic ph, input logic [1:0] lv);
    return mk(3'd0, lv, ph, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic logic [10:0] ex_run(input logic [1:0] lv, input logic tr);
    return mk(3'd1, lv, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, tr);
  endfunction
  function automatic logic [10:0] ex_pause(input logic [1:0] lv);
    return mk(3'd2, lv, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic logic [10:0] ex_hold(input logic [1:0] lv);
    return mk(3'd3, lv, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic logic [10:0] ex_over();
    return mk(3'd4, 2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction
  function automatic logic [10:0] ex_fin(input logic [1:0] lv);
    return mk(3'd5, lv, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
  endfunction

  function automatic logic [10:0] obs();
    return {state, lives, start_en, crash_en, finish_en,
            pause, game_run, timer_reset};
  endfunction

  task automatic apply(input logic [5:0] s);
    {reset, refresh_tick, btn_start, btn_pause, crash, finish} = s;
  endtask

  always @(negedge clk) begin
    if (armed) begin
      checks++;
      if ((32'(start_en) + 32'(crash_en) + 32'(finish_en)) > 1) begin
        errors++;
        $display("FAIL banner_exclusive se=%b ce=%b fe=%b required at most one",
                 start_en, crash_en, finish_en);
      end
    end
  end

  task automatic test_reset();
    logic [5:0]  st [5];
    logic [10:0] ex [5];
    st = '{S(1,0,1,0,0,0), S(1,0,1,0,0,0), S(0,0,1,0,0,0),
           S(0,0,1,0,0,0), S(0,0,0,0,0,0)};
    ex = '{ex_title(1,2), ex_title(1,2), ex_title(1,2),
           ex_title(1,2), ex_title(1,2)};
    for (int i = 0; i < 5; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      got = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset[%0d] got=%b required=%b", i, got, want);
      end
    end
  endtask

  task automatic test_blink();
    logic [10:0] ex [8];
    ex = '{ex_title(1,2), ex_title(1,2), ex_title(0,2), ex_title(0,2),
           ex_title(1,2), ex_title(1,2), ex_title(0,2), ex_title(0,2)};
    for (int i = 0; i < 8; i++) begin
      apply(S(0,1,0,0,0,0));
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      got = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL blink[%0d] got=%b required=%b", i, got, want);
      end
    end
  endtask

  task automatic test_start();
    logic [5:0]  st [4];
    logic [10:0] ex [4];
    st = '{S(0,0,1,0,0,0), S(0,0,0,0,0,0), S(0,0,1,0,0,0), S(0,0,0,0,0,0)};
    ex = '{ex_run(2,1), ex_run(2,0), ex_run(2,0), ex_run(2,0)};
    for (int i = 0; i < 4; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      got = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL start[%0d] got=%b required=%b", i, got, want);
      end
    end
  endtask

  task automatic test_crash_hold();
    logic [5:0]  st [8];
    logic [10:0] ex [8];
    st = '{S(0,0,0,0,1,0), S(0,1,0,0,1,0), S(0,1,1,0,1,0), S(0,1,0,1,1,0),
           S(0,1,0,0,1,0), S(0,0,0,0,1,0), S(0,0,0,0,0,0), S(0,0,0,0,0,0)};
    ex = '{ex_hold(1), ex_hold(1), ex_hold(1), ex_hold(1),
           ex_hold(1), ex_hold(1), ex_run(1,0), ex_run(1,0)};
    for (int i = 0; i < 8; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      got = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL crash_hold[%0d] got=%b required=%b", i, got, want);
      end
    end
  endtask

  task automatic test_finish();
    logic [5:0]  st [9];
    logic [10:0] ex [9];
    st = '{S(0,0,0,0,1,1), S(0,1,0,0,0,0), S(0,1,0,0,0,0),
           S(0,0,1,0,0,0), S(0,0,0,0,0,0), S(0,1,0,0,0,0),
           S(0,1,0,0,0,0), S(0,0,1,0,0,0), S(0,0,0,0,0,0)};
    ex = '{ex_fin(1), ex_fin(1), ex_fin(1), ex_fin(1), ex_fin(1),
           ex_fin(1), ex_fin(1), ex_title(1,1), ex_title(1,1)};
    for (int i = 0; i < 9; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      got = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL finish[%0d] got=%b required=%b", i, got, want);
      end
    end
  endtask

  task automatic test_pause();
    logic [5:0]  st [10];
    logic [10:0] ex [10];
    st = '{S(0,0,1,0,0,0), S(0,0,0,0,0,0), S(0,0,0,1,0,0),
           S(0,0,0,0,0,0), S(0,0,0,0,1,0), S(0,0,0,0,0,1),
           S(0,1,1,0,1,1), S(0,0,0,0,0,0), S(0,0,0,1,0,0),
           S(0,0,0,0,0,0)};
    ex = '{ex_run(2,1), ex_run(2,0), ex_pause(2), ex_pause(2),
           ex_pause(2), ex_pause(2), ex_pause(2), ex_pause(2),
           ex_run(2,0), ex_run(2,0)};
    for (int i = 0; i < 10; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      got = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL pause[%0d] got=%b required=%b", i, got, want);
      end
    end
  endtask

  task automatic test_game_over();
    logic [5:0]  st [14];
    logic [10:0] ex [14];
    st = '{S(0,0,0,0,1,0), S(0,1,0,0,0,0), S(0,1,0,0,0,0),
           S(0,1,0,0,0,0), S(0,1,0,0,0,0), S(0,0,0,0,0,0),
           S(0,0,0,0,1,0), S(0,0,0,0,0,0), S(0,0,1,0,0,0),
           S(0,1,0,0,0,0), S(1,1,0,0,0,0), S(0,0,0,0,0,0),
           S(1,0,1,0,0,0), S(0,0,0,0,0,0)};
    ex = '{ex_hold(1), ex_hold(1), ex_hold(1), ex_hold(1),
           ex_hold(1), ex_run(1,0), ex_over(), ex_over(),
           ex_over(), ex_over(), ex_title(1,2), ex_title(1,2),
           ex_title(1,2), ex_title(1,2)};
    for (int i = 0; i < 14; i++) begin
      apply(st[i]);
      exp_q.push_back(ex[i]);
      @(posedge clk); #1;
      got = obs();
      want = exp_q.pop_front();
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL game_over[%0d] got=%b required=%b", i, got, want);
      end
    end
  endtask

  initial begin
    apply(S(1,0,1,0,0,0));
    repeat (3) @(posedge clk);
    #1;
    armed = 1'b1;
    test_reset();
    test_blink();
    test_start();
    test_crash_hold();
    test_finish();
    test_pause();
    test_game_over();
    armed = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
